// File: rtl/ecap5_dproc_pkg.sv
// ecap5_dproc_pkg - shared types and constants of the ECAP5-DPROC pipeline.
//
// Provides the RV32I opcode constants, the ALU operation and instruction
// class enumerations, the decoded-instruction record carried from decode to
// execute, and small decode helpers shared by the decode stage.
package ecap5_dproc_pkg;

    // RV32I major opcodes (full 7 bits, so instr[1:0] != 2'b11 never matches)
    localparam logic [6:0] OPCODE_ALU_REG = 7'b0110011;
    localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPCODE_FENCE   = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM  = 7'b1110011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    // CLASS_NONE (0) marks an unlisted opcode and is also the reset value.
    typedef enum logic [3:0] {
        CLASS_NONE    = 4'd0,
        CLASS_ALU_REG = 4'd1,
        CLASS_ALU_IMM = 4'd2,
        CLASS_LOAD    = 4'd3,
        CLASS_STORE   = 4'd4,
        CLASS_BRANCH  = 4'd5,
        CLASS_JAL     = 4'd6,
        CLASS_JALR    = 4'd7,
        CLASS_LUI     = 4'd8,
        CLASS_AUIPC   = 4'd9,
        CLASS_FENCE   = 4'd10,
        CLASS_SYSTEM  = 4'd11
    } instr_class_t;

    typedef struct packed {
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [31:0]  imm;
        logic [2:0]   funct3;
        alu_op_t      alu_op;
        instr_class_t instr_class;
        logic         illegal;
    } decoded_t;

    function automatic instr_class_t classify(input logic [6:0] opcode);
        case (opcode)
            OPCODE_ALU_REG: return CLASS_ALU_REG;
            OPCODE_ALU_IMM: return CLASS_ALU_IMM;
            OPCODE_LOAD:    return CLASS_LOAD;
            OPCODE_STORE:   return CLASS_STORE;
            OPCODE_BRANCH:  return CLASS_BRANCH;
            OPCODE_JAL:     return CLASS_JAL;
            OPCODE_JALR:    return CLASS_JALR;
            OPCODE_LUI:     return CLASS_LUI;
            OPCODE_AUIPC:   return CLASS_AUIPC;
            OPCODE_FENCE:   return CLASS_FENCE;
            OPCODE_SYSTEM:  return CLASS_SYSTEM;
            default:        return CLASS_NONE;
        endcase
    endfunction

    // alt selects SUB for funct3=000 and SRA for funct3=101.
    function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3,
                                                input logic       alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decm_imm.sv
// decm_imm - combinational RV32I immediate generator.
//
// Ports:
//   instr_i  in  [31:7]  instruction bits above the opcode (all feed some format)
//   class_i  in  4       decoded instruction class, selects the immediate format
//   imm_o    out 32      sign-extended immediate; 0 for classes without one
module decm_imm
    import ecap5_dproc_pkg::*;
(
    input  logic [31:7]  instr_i,
    input  instr_class_t class_i,
    output logic [31:0]  imm_o
);

    logic [31:0] imm_i_type;
    logic [31:0] imm_s_type;
    logic [31:0] imm_b_type;
    logic [31:0] imm_u_type;
    logic [31:0] imm_j_type;

    assign imm_i_type = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_type = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_type = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_type = {instr_i[31:12], 12'h000};
    assign imm_j_type = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        // NOTE: default first so every path assigns imm_o and no latch is inferred.
        imm_o = '0;
        case (class_i)
            CLASS_ALU_IMM, CLASS_LOAD, CLASS_JALR,
            CLASS_FENCE, CLASS_SYSTEM:  imm_o = imm_i_type;
            CLASS_STORE:                imm_o = imm_s_type;
            CLASS_BRANCH:               imm_o = imm_b_type;
            CLASS_LUI, CLASS_AUIPC:     imm_o = imm_u_type;
            CLASS_JAL:                  imm_o = imm_j_type;
            default:                    imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decm.sv
// decm - RV32I instruction decode stage of the ECAP5-DPROC pipeline.
//
// Decodes one instruction per input handshake into a record that is held in a
// single-entry output register until execute consumes it.
//
// Ports:
//   clk_i           in   1   clock, rising edge
//   rst_ni          in   1   asynchronous active-low reset
//   flush_i         in   1   drop held record and any instruction offered this cycle
//   input_valid_i   in   1   instr_i valid (from fetch)
//   input_ready_o   out  1   decode can accept this cycle
//   instr_i         in   32  raw instruction
//   output_valid_o  out  1   decoded record valid
//   output_ready_i  in   1   execute consumes the record this cycle
//   rd_o/rs1_o/rs2_o out 5   register indices, 0 when the class does not use them
//   imm_o           out  32  sign-extended immediate
//   funct3_o        out  3   instr[14:12]
//   alu_op_o        out  4   alu_op_t
//   instr_class_o   out  4   instr_class_t
//   illegal_o       out  1   instruction is not legal RV32I
module decm
    import ecap5_dproc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic [31:0] instr_i,
    output logic        output_valid_o,
    input  logic        output_ready_i,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [31:0] imm_o,
    output logic [2:0]  funct3_o,
    output logic [3:0]  alu_op_o,
    output logic [3:0]  instr_class_o,
    output logic        illegal_o
);

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    instr_class_t instr_class;
    logic [31:0]  imm;
    decoded_t     dec;
    decoded_t     rec_q;
    logic         output_valid_q;
    logic         accept;

    assign opcode      = instr_i[6:0];
    assign funct3      = instr_i[14:12];
    assign funct7      = instr_i[31:25];
    assign instr_class = classify(opcode);

    decm_imm u_imm (
        .instr_i (instr_i[31:7]),
        .class_i (instr_class),
        .imm_o   (imm)
    );

    always_comb begin
        dec             = '0;
        dec.funct3      = funct3;
        dec.imm         = imm;
        dec.instr_class = instr_class;
        dec.alu_op      = ALU_ADD;
        dec.illegal     = (instr_class == CLASS_NONE);

        case (instr_class)
            CLASS_ALU_REG, CLASS_ALU_IMM, CLASS_LOAD, CLASS_JAL,
            CLASS_JALR, CLASS_LUI, CLASS_AUIPC: dec.rd = instr_i[11:7];
            default:                            dec.rd = '0;
        endcase

        case (instr_class)
            CLASS_NONE, CLASS_JAL, CLASS_LUI, CLASS_AUIPC: dec.rs1 = '0;
            default:                                       dec.rs1 = instr_i[19:15];
        endcase

        case (instr_class)
            CLASS_ALU_REG, CLASS_STORE, CLASS_BRANCH: dec.rs2 = instr_i[24:20];
            default:                                  dec.rs2 = '0;
        endcase

        case (instr_class)
            CLASS_ALU_REG: begin
                dec.alu_op = alu_from_funct3(funct3, instr_i[30]);
                if (funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT)
                    dec.illegal = 1'b1;
                // The alternate encoding only exists for SUB and SRA.
                if (funct7 == FUNCT7_ALT && funct3 != 3'b000 && funct3 != 3'b101)
                    dec.illegal = 1'b1;
            end
            CLASS_ALU_IMM: begin
                // ADDI has no SUB form; instr[30] only selects SRAI.
                dec.alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && instr_i[30]);
                if (funct3 == 3'b001 && funct7 != FUNCT7_BASE)
                    dec.illegal = 1'b1;
                if (funct3 == 3'b101 && funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT)
                    dec.illegal = 1'b1;
            end
            CLASS_LUI: dec.alu_op = ALU_PASS_B;
            default:   dec.alu_op = ALU_ADD;
        endcase

        // Illegal records still travel downstream but with a harmless ALU op.
        if (dec.illegal)
            dec.alu_op = ALU_ADD;
    end

    // Flush frees the stage in the same cycle so fetch can refill it immediately.
    assign input_ready_o = !output_valid_q || output_ready_i || flush_i;
    assign accept        = input_valid_i && input_ready_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            output_valid_q <= 1'b0;
            // NOTE: the record is reset too, because every field output must read 0 out of reset.
            rec_q          <= '0;
        end else if (flush_i) begin
            output_valid_q <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking so all state in this block updates from pre-edge values.
            output_valid_q <= 1'b1;
            rec_q          <= dec;
        end else if (output_ready_i) begin
            output_valid_q <= 1'b0;
        end
    end

    assign output_valid_o = output_valid_q;
    assign rd_o           = rec_q.rd;
    assign rs1_o          = rec_q.rs1;
    assign rs2_o          = rec_q.rs2;
    assign imm_o          = rec_q.imm;
    assign funct3_o       = rec_q.funct3;
    assign alu_op_o       = rec_q.alu_op;
    assign instr_class_o  = rec_q.instr_class;
    assign illegal_o      = rec_q.illegal;

endmodule

// File: doc/decm.md
# decm

Instruction decode stage of the ECAP5-DPROC pipeline, directly downstream of the instruction fetch module. It accepts one 32-bit RV32I instruction per valid/ready handshake and decodes it combinationally into register indices, a sign-extended immediate, an ALU operation, an instruction class and an illegal-instruction flag. The decoded record is registered in a single-entry output stage with its own valid/ready handshake toward execute. A flush input discards in-flight work on control-flow changes.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset, asynchronous and active-low
- flush_i  in  1  discard held record and any instruction accepted this cycle
- input_valid_i  in  1  instr_i valid (from fetch output_valid)
- input_ready_o  out  1  decode can accept this cycle (to fetch output_ready)
- instr_i  in  32  raw instruction
- output_valid_o  out  1  decoded record valid
- output_ready_i  in  1  execute consumes record this cycle
- rd_o  out  5  destination register; 0 when class has no rd
- rs1_o  out  5  source 1; 0 when unused
- rs2_o  out  5  source 2; 0 when unused
- imm_o  out  32  sign-extended immediate; 0 for R-type
- funct3_o  out  3  instr[14:12]
- alu_op_o  out  4  alu_op_t
- instr_class_o  out  4  instr_class_t
- illegal_o  out  1  instruction not legal RV32I

## Operation
- Classes by opcode: ALU_REG 0110011, ALU_IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, FENCE 0001111, SYSTEM 1110011.
- Immediates: I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); U = {instr[31:12],12'h0}; J = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
- rd used: ALU_REG, ALU_IMM, LOAD, JAL, JALR, LUI, AUIPC; else 0. rs1 used: all except JAL, LUI, AUIPC. rs2 used: ALU_REG, STORE, BRANCH.
- alu_op: ALU_REG/ALU_IMM from funct3 (+instr[30] for SUB/SRA; ADDI never SUB); LUI → PASS_B; all others → ADD.
- illegal_o = 1 when instr[1:0] != 2'b11, opcode unlisted, ALU_REG funct7 not in {0000000, 0100000}, 0100000 with funct3 not in {000,101}, or shift-immediate funct7 not in {0000000, 0100000 (SRAI only)}. Illegal records still flow with class/alu_op ADD defaults.
- Accept condition: input_valid_i && input_ready_o && !flush_i. input_ready_o = !output_valid_q || output_ready_i || flush_i.
- Output register: EMPTY/FULL (= output_valid_q). Accept → FULL, fields loaded. Consume without accept → EMPTY. Consume with accept → FULL, new record. Flush → EMPTY, no load.

## Timing
- Latency: record visible on output 1 cycle after accepting edge; throughput 1/cycle with output_ready_i high.
- input_ready_o depends combinationally on output_ready_i and flush_i; no combinational path from instr_i to outputs.
- Outputs stable while output_valid_o=1 and output_ready_i=0.
- Reset: output_valid_o=0, all field outputs 0, alu_op ADD (0), class 0; takes effect immediately on rst_ni falling, independent of clock, including mid-transfer. input_ready_o=1 after reset.
- flush_i and output_ready_i same cycle: flush wins, record dropped.

## Structure
- ecap5_dproc_pkg gains: opcode constants, alu_op_t (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B), instr_class_t.
- Sub-module decm_imm: combinational immediate generator (instr → imm by class).

## Test plan
- addi x1,x2,-1 (0xFFF10093) → class ALU_IMM, rd=1, rs1=2, rs2=0, imm=0xFFFFFFFF, alu ADD, valid next cycle.
- sub x3,x4,x5 (0x405201B3) → ALU_REG, rd=3, rs1=4, rs2=5, imm=0, alu SUB, illegal 0.
- beq x0,x0,-4 (0xFE000EE3) → BRANCH, rd=0, imm=0xFFFFFFFC, alu ADD.
- Backpressure: FULL, output_ready_i=0 for 3 cycles → input_ready_o=0, outputs frozen; raise ready → same-cycle accept of next instr, new record following cycle.
- flush_i while FULL with input_valid_i=1 → output_valid_o=0 next cycle, instruction discarded.
- 0x00000000 → illegal_o=1; then drive rst_ni low between edges → output_valid_o=0 immediately.
